// File: rtl/ucode_pkg.sv
// Shared types and constants for the microcode dispatcher: FSM state encoding
// and the opcode field position within an instruction word.
package ucode_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    HALT,
    ERROR
  } dispatch_state_t;

  localparam int         OPCODE_MSB          = 31;
  localparam int         OPCODE_LSB          = 26;
  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/ucode_instr_fifo.sv
// Show-ahead instruction FIFO; pointers carry an extra wrap bit so that full
// and empty can be told apart when the address bits match.
module ucode_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset: only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ucode_dispatcher.sv
// Microcode dispatcher: pops buffered instructions, pulses sos per segment,
// waits for eos behind a one-cycle guard, and traps halt opcodes and hangs.
module ucode_dispatcher
  import ucode_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 4,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter int         CNT_WIDTH      = 16,
  parameter logic [5:0] HALT_OPCODE    = HALT_OPCODE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [31:0]          instr_data,
  output logic                 instr_ready,
  output logic [5:0]           opcode_out,
  output logic                 sos_out,
  input  logic                 eos_in,
  output logic                 busy,
  output logic                 halted,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  dispatch_state_t      state_q, state_d;
  logic [5:0]           opcode_q, opcode_d;
  logic                 sos_q, sos_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;

  logic        fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [31:0] fifo_dout;
  logic [5:0]  head_op;
  logic        take_head;

  assign instr_ready = !fifo_full && (state_q != HALT) && (state_q != ERROR);
  assign fifo_push   = instr_valid && instr_ready;
  assign head_op     = opcode_of(fifo_dout);

  ucode_instr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (instr_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    sos_d     = 1'b0;
    busy_d    = busy_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    wdog_d    = wdog_q;
    take_head = 1'b0;

    case (state_q)
      IDLE: begin
        take_head = !fifo_empty;
      end
      ISSUE: begin
        state_d = SETTLE;
      end
      // eos_in still reflects the previous segment here, so it is not sampled.
      SETTLE: begin
        state_d = WAIT;
        wdog_d  = '0;
      end
      WAIT: begin
        if (eos_in) begin
          count_d   = count_q + CNT_WIDTH'(1);
          busy_d    = 1'b0;
          state_d   = IDLE;
          take_head = !fifo_empty;
        end else if (wdog_q == WD_LAST) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      HALT, ERROR: begin
      end
      default: state_d = IDLE;
    endcase

    // Shared by IDLE and the back-to-back retire path in WAIT.
    if (take_head) begin
      opcode_d = head_op;
      if (head_op == HALT_OPCODE) begin
        state_d  = HALT;
        halted_d = 1'b1;
        busy_d   = 1'b0;
      end else begin
        state_d = ISSUE;
        sos_d   = 1'b1;
        busy_d  = 1'b1;
      end
    end
    fifo_pop = take_head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      sos_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      sos_q     <= sos_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
      wdog_q    <= wdog_d;
    end
  end

  assign opcode_out  = opcode_q;
  assign sos_out     = sos_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_q;
  assign instr_count = count_q;

endmodule
